// File: rtl/tx_serial_param_pkg.sv
// Shared definitions for the parameterised serial transmitter: FSM state codes,
// parity-mode constants and the frame-length helper.
package tx_serial_param_pkg;

  localparam logic [3:0] StInicial     = 4'h0;
  localparam logic [3:0] StPreparacao  = 4'h1;
  localparam logic [3:0] StEspera      = 4'h3;
  localparam logic [3:0] StTransmissao = 4'h7;
  localparam logic [3:0] StFinalTx     = 4'hF;

  localparam int unsigned ParNone = 0;
  localparam int unsigned ParEven = 1;
  localparam int unsigned ParOdd  = 2;

  // Bits per frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_len(input int unsigned n_dados,
                                            input int unsigned paridade,
                                            input int unsigned n_stop);
    return 1 + n_dados + ((paridade != ParNone) ? 1 : 0) + n_stop;
  endfunction

endpackage

// File: rtl/tx_serial_param_fd.sv
// Transmitter datapath: frame shift register and bit counter.
module tx_serial_param_fd #(
  parameter int unsigned N_DADOS  = 8,
  parameter int unsigned PARIDADE = 0,
  parameter int unsigned N_STOP   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic               desloca,
  input  logic [N_DADOS-1:0] dados,
  output logic               saida,
  output logic               fim,
  output logic               penultimo
);
  import tx_serial_param_pkg::*;

  localparam int unsigned L  = frame_len(N_DADOS, PARIDADE, N_STOP);
  localparam int unsigned CW = $clog2(L + 1);

  logic [L-1:0]  quadro;
  logic [L-1:0]  reg_q;
  logic [CW-1:0] cont_q;

  // Stop bits come from the all-ones default.
  always_comb begin
    quadro            = '1;
    quadro[0]         = 1'b0;
    quadro[N_DADOS:1] = dados;
    if (PARIDADE == ParEven) begin
      quadro[N_DADOS+1] = ^dados;
    end else if (PARIDADE == ParOdd) begin
      quadro[N_DADOS+1] = ~^dados;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_q  <= '1;
      cont_q <= '0;
    end else if (carrega) begin
      reg_q  <= quadro;
      cont_q <= '0;
    end else if (desloca) begin
      reg_q  <= {1'b1, reg_q[L-1:1]};
      cont_q <= cont_q + CW'(1);
    end
  end

  always_comb begin
    saida     = reg_q[0];
    fim       = (cont_q == CW'(L));
    penultimo = (cont_q == CW'(L - 1));
  end

endmodule

// File: rtl/tx_serial_param.sv
// Parameterised serial transmitter (Moore FSM + datapath). Define TX_SERIAL_BUF_EN
// to add a one-entry request buffer and the erro_overrun output.
module tx_serial_param #(
  parameter int unsigned N_DADOS  = 8,
  parameter int unsigned PARIDADE = 0,
  parameter int unsigned N_STOP   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               partida,
  input  logic [N_DADOS-1:0] dados,
  input  logic               tick,
  output logic               zera_tick,
  output logic               saida_serial,
  output logic               ocupado,
  output logic               pronto,
`ifdef TX_SERIAL_BUF_EN
  output logic               erro_overrun,
`endif
  output logic [3:0]         db_estado
);
  import tx_serial_param_pkg::*;

  logic [3:0]         estado_q, estado_d;
  logic [N_DADOS-1:0] dados_q;
  logic               aceita;
  logic               bit_serial, fim, penultimo;

`ifdef TX_SERIAL_BUF_EN
  logic               usa_buf;
  logic               buf_cheio_q;
  logic [N_DADOS-1:0] buf_q;
  logic               erro_q;
`endif

  always_comb begin
    estado_d = estado_q;
    aceita   = 1'b0;
`ifdef TX_SERIAL_BUF_EN
    usa_buf  = 1'b0;
`endif
    case (estado_q)
      StInicial: begin
`ifdef TX_SERIAL_BUF_EN
        // A request captured during final_tx is still pending here.
        if (buf_cheio_q) begin
          estado_d = StPreparacao;
          usa_buf  = 1'b1;
        end else
`endif
        if (partida) begin
          estado_d = StPreparacao;
          aceita   = 1'b1;
        end
      end
      StPreparacao:  estado_d = StEspera;
      StEspera: begin
        if (fim) begin
          estado_d = StFinalTx;
        end else if (tick) begin
          estado_d = StTransmissao;
        end
      end
      StTransmissao: estado_d = penultimo ? StFinalTx : StEspera;
      StFinalTx: begin
`ifdef TX_SERIAL_BUF_EN
        if (buf_cheio_q) begin
          estado_d = StPreparacao;
          usa_buf  = 1'b1;
        end else
`endif
        estado_d = StInicial;
      end
      default:       estado_d = StInicial;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Payload held from acceptance until preparacao loads the frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados_q <= '0;
    end else if (aceita) begin
      dados_q <= dados;
`ifdef TX_SERIAL_BUF_EN
    end else if (usa_buf) begin
      dados_q <= buf_q;
`endif
    end
  end

`ifdef TX_SERIAL_BUF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_cheio_q <= 1'b0;
      buf_q       <= '0;
      erro_q      <= 1'b0;
    end else begin
      erro_q <= partida && buf_cheio_q;
      if (usa_buf) begin
        buf_cheio_q <= 1'b0;
      end else if (partida && ocupado && !buf_cheio_q) begin
        buf_cheio_q <= 1'b1;
        buf_q       <= dados;
      end
    end
  end

  always_comb erro_overrun = erro_q;
`endif

  tx_serial_param_fd #(
    .N_DADOS  (N_DADOS),
    .PARIDADE (PARIDADE),
    .N_STOP   (N_STOP)
  ) u_fd (
    .clock     (clock),
    .reset     (reset),
    .carrega   (estado_q == StPreparacao),
    .desloca   (estado_q == StTransmissao),
    .dados     (dados_q),
    .saida     (bit_serial),
    .fim       (fim),
    .penultimo (penultimo)
  );

  always_comb begin
    zera_tick    = (estado_q == StPreparacao);
    ocupado      = (estado_q != StInicial);
    pronto       = (estado_q == StFinalTx);
    db_estado    = estado_q;
    saida_serial = (estado_q == StEspera || estado_q == StTransmissao) ? bit_serial : 1'b1;
  end

endmodule

// File: tb/tb_tx_serial_param.sv
// Bench for tx_serial_param: three configurations (8N1, 7E1, 8O2) driven against a
// bit-list reference model; buffer checks compile in with TX_SERIAL_BUF_EN.
module tb_tx_serial_param;

  localparam int unsigned ND [3] = '{8, 7, 8};
  localparam int unsigned PR [3] = '{0, 1, 2};
  localparam int unsigned NS [3] = '{1, 1, 2};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] partida = '0;
  logic       tick = 1'b0;
  logic [7:0] d0 = '0;
  logic [6:0] d1 = '0;
  logic [7:0] d2 = '0;
  logic [2:0] saida, ocupado, pronto, zera;
  logic [3:0] db [3];
`ifdef TX_SERIAL_BUF_EN
  logic [2:0] eo;
  int         eo_cnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Expected line bits per instance, with an end-of-frame marker.
  bit exp_bits [3][48];
  bit exp_last [3][48];
  int head [3] = '{0, 0, 0};
  int tail [3] = '{0, 0, 0};

  always #5 clock = ~clock;

  tx_serial_param #(.N_DADOS(8), .PARIDADE(0), .N_STOP(1)) u_dut0 (
    .clock(clock), .reset(reset), .partida(partida[0]), .dados(d0), .tick(tick),
    .zera_tick(zera[0]), .saida_serial(saida[0]), .ocupado(ocupado[0]), .pronto(pronto[0]),
`ifdef TX_SERIAL_BUF_EN
    .erro_overrun(eo[0]),
`endif
    .db_estado(db[0])
  );

  tx_serial_param #(.N_DADOS(7), .PARIDADE(1), .N_STOP(1)) u_dut1 (
    .clock(clock), .reset(reset), .partida(partida[1]), .dados(d1), .tick(tick),
    .zera_tick(zera[1]), .saida_serial(saida[1]), .ocupado(ocupado[1]), .pronto(pronto[1]),
`ifdef TX_SERIAL_BUF_EN
    .erro_overrun(eo[1]),
`endif
    .db_estado(db[1])
  );

  tx_serial_param #(.N_DADOS(8), .PARIDADE(2), .N_STOP(2)) u_dut2 (
    .clock(clock), .reset(reset), .partida(partida[2]), .dados(d2), .tick(tick),
    .zera_tick(zera[2]), .saida_serial(saida[2]), .ocupado(ocupado[2]), .pronto(pronto[2]),
`ifdef TX_SERIAL_BUF_EN
    .erro_overrun(eo[2]),
`endif
    .db_estado(db[2])
  );

`ifdef TX_SERIAL_BUF_EN
  always @(posedge clock) if (eo[0]) eo_cnt <= eo_cnt + 1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic qpush(input int i, input bit b, input bit last);
    exp_bits[i][tail[i]] = b;
    exp_last[i][tail[i]] = last;
    tail[i]++;
  endtask

  // Frame as a bit list: start 0, data LSB first, parity, stop 1s.
  task automatic push_frame(input int i, input logic [8:0] d);
    int ones = 0;
    qpush(i, 1'b0, 1'b0);
    for (int j = 0; j < int'(ND[i]); j++) begin
      qpush(i, d[j], 1'b0);
      ones += int'(d[j]);
    end
    if (PR[i] == 1) qpush(i, bit'(ones % 2), 1'b0);
    else if (PR[i] == 2) qpush(i, bit'(1 - ones % 2), 1'b0);
    for (int s = 0; s < int'(NS[i]); s++) qpush(i, 1'b1, s == int'(NS[i]) - 1);
  endtask

  task automatic start(input logic [2:0] mask, input logic [8:0] v0, input logic [8:0] v1,
                       input logic [8:0] v2);
    logic [8:0] v [3];
    v = '{v0, v1, v2};
    @(posedge clock); #1;
    d0 = v0[7:0]; d1 = v1[6:0]; d2 = v2[7:0];
    partida = mask;
    @(negedge clock);
    for (int i = 0; i < 3; i++)
      if (mask[i]) check($sformatf("ocupado_idle[%0d]", i), 32'(ocupado[i]), 32'd0);
    @(posedge clock); #1;
    partida = '0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        check($sformatf("zera_tick[%0d]", i), 32'(zera[i]), 32'd1);
        check($sformatf("db_prep[%0d]", i), 32'(db[i]), 32'h1);
        if (head[i] == tail[i]) begin
          head[i] = 0;
          tail[i] = 0;
        end
        push_frame(i, v[i]);
      end
    end
  endtask

  task automatic run_ticks(input int n);
    bit lastf [3];
    bit any_last;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 4)) @(posedge clock);
      #1 tick = 1'b1;
      @(negedge clock);
      any_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (head[i] < tail[i]) begin
          check($sformatf("line[%0d]", i), 32'(saida[i]), 32'(exp_bits[i][head[i]]));
          lastf[i] = exp_last[i][head[i]];
          head[i]++;
        end else begin
          check($sformatf("line_idle[%0d]", i), 32'(saida[i]), 32'd1);
          lastf[i] = 1'b0;
        end
        any_last |= lastf[i];
      end
      @(posedge clock); #1 tick = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 3; i++) check($sformatf("pronto_early[%0d]", i), 32'(pronto[i]), 32'd0);
      @(negedge clock);
      for (int i = 0; i < 3; i++)
        check($sformatf("pronto[%0d]", i), 32'(pronto[i]), 32'(lastf[i]));
      if (any_last) begin
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
          if (lastf[i]) begin
            check($sformatf("pronto_len[%0d]", i), 32'(pronto[i]), 32'd0);
            check($sformatf("ocupado_after[%0d]", i), 32'(ocupado[i]),
                  32'(head[i] < tail[i]));
            check($sformatf("db_after[%0d]", i), 32'(db[i]), (head[i] < tail[i]) ? 32'h1 : 32'h0);
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_line[%0d]", i), 32'(saida[i]), 32'd1);
      check($sformatf("rst_db[%0d]", i), 32'(db[i]), 32'h0);
      check($sformatf("rst_busy[%0d]", i), 32'(ocupado[i]), 32'd0);
      check($sformatf("rst_pronto[%0d]", i), 32'(pronto[i]), 32'd0);
      check($sformatf("rst_zera[%0d]", i), 32'(zera[i]), 32'd0);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // 8N1 0x55, 7E1 0x41, 8O2 0x00
    start(3'b111, 9'h055, 9'h041, 9'h000);
    run_ticks(13);

    for (int r = 0; r < 6; r++) begin
      start(3'b111, 9'($urandom), 9'($urandom), 9'($urandom));
      run_ticks(13);
    end

    // Asynchronous reset mid-frame, after the 4th tick; DUT0 is driving a 0 there.
    start(3'b111, 9'h000, 9'($urandom), 9'($urandom));
    run_ticks(4);
    check("pre_rst_line[0]", 32'(saida[0]), 32'd0);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_line[%0d]", i), 32'(saida[i]), 32'd1);
      check($sformatf("async_db[%0d]", i), 32'(db[i]), 32'h0);
      check($sformatf("async_busy[%0d]", i), 32'(ocupado[i]), 32'd0);
      head[i] = 0;
      tail[i] = 0;
    end
    @(posedge clock); #1 reset = 1'b1;
    start(3'b111, 9'($urandom), 9'($urandom), 9'($urandom));
    run_ticks(13);

`ifdef TX_SERIAL_BUF_EN
    start(3'b001, 9'h0A5, 9'h000, 9'h000);
    run_ticks(2);
    @(posedge clock); #1 partida = 3'b001; d0 = 8'h3C;
    @(negedge clock); check("overrun_quiet", 32'(eo[0]), 32'd0);
    @(posedge clock); #1 partida = '0;
    @(negedge clock); check("overrun_capture", 32'(eo[0]), 32'd0);
    push_frame(0, 9'h03C);
    run_ticks(1);
    @(posedge clock); #1 partida = 3'b001; d0 = 8'hFF;
    @(negedge clock); check("overrun_pre", 32'(eo[0]), 32'd0);
    @(posedge clock); #1 partida = '0;
    @(negedge clock); check("overrun_pulse", 32'(eo[0]), 32'd1);
    run_ticks(20);
    check("overrun_count", 32'(eo_cnt), 32'd1);
`else
    // Request during a frame is ignored without the buffer.
    start(3'b001, 9'($urandom), 9'h000, 9'h000);
    run_ticks(3);
    @(posedge clock); #1 partida = 3'b001; d0 = 8'($urandom);
    @(posedge clock); #1 partida = '0;
    run_ticks(10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
